pipe_hazard_ctrl: RTL and testbench

Parametrised pipeline control unit: the next generation of the CPU's stall/flush controller.
- Accepts one stall request per stage (any STAGES) and produces the per-stage stall vector.
- Resolves exceptions into a flush plus handler redirect address; holds flush for a configurable number of cycles.
- Adds a stall watchdog and a stalled-cycle performance counter.
- Sits beside the pipeline registers and PC, driven by ID/EX/MEM hazard logic and CP0.

---
 rtl/pipe_hazard_ctrl.sv | 116 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush controller with exception redirect and stall watchdog
module pipe_hazard_ctrl #(
  parameter int              STAGES        = 6,
  parameter int              ADDR_W        = 32,
  parameter int              EXC_W         = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE    = ADDR_W'(32'h0000_0000),
  parameter logic [ADDR_W-1:0] INT_OFFSET  = ADDR_W'(32'h0000_0020),
  parameter logic [ADDR_W-1:0] GEN_OFFSET  = ADDR_W'(32'h0000_0040),
  parameter int              FLUSH_CYCLES  = 1,
  parameter int              STALL_TIMEOUT = 255,
  parameter logic [EXC_W-1:0] EXC_INT      = EXC_W'(1),
  parameter logic [EXC_W-1:0] EXC_SYSCALL  = EXC_W'(8),
  parameter logic [EXC_W-1:0] EXC_INVALID  = EXC_W'(10),
  parameter logic [EXC_W-1:0] EXC_TRAP     = EXC_W'(13),
  parameter logic [EXC_W-1:0] EXC_OVF      = EXC_W'(12),
  parameter logic [EXC_W-1:0] EXC_ERET     = EXC_W'(14)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq_i,
  input  logic [EXC_W-1:0]  exception_i,
  input  logic [ADDR_W-1:0] cp0_epc_i,
  output logic [STAGES-1:0] stall_o,
  output logic              flush_o,
  output logic [ADDR_W-1:0] exec_handler_addr_o,
  output logic              stall_timeout_o,
  output logic [31:0]       stall_cnt_o
);

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
  localparam int WD_W = $clog2(STALL_TIMEOUT + 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t            state;
  logic [FC_W-1:0]   flush_cnt;
  logic [ADDR_W-1:0] latched_addr;
  logic [WD_W-1:0]   wd_cnt;
  logic [ADDR_W-1:0] target_addr;
  logic [STAGES-1:0] therm;
  logic              exc_take;

  always_comb begin
    target_addr = VEC_BASE + GEN_OFFSET;
    case (exception_i)
      EXC_INT:                                    target_addr = VEC_BASE + INT_OFFSET;
      EXC_SYSCALL, EXC_INVALID, EXC_TRAP, EXC_OVF: target_addr = VEC_BASE + GEN_OFFSET;
      EXC_ERET:                                   target_addr = cp0_epc_i;
      default:                                    target_addr = VEC_BASE + GEN_OFFSET;
    endcase
  end

  // Stage k stalls whenever it or any later stage requests: stalls propagate upstream.
  always_comb begin
    therm = '0;
    for (int i = 0; i < STAGES; i++)
      therm[i] = |(stallreq_i >> i);
  end

  assign exc_take = (state == RUN) && (exception_i != '0);

  always_comb begin
    stall_o             = '0;
    flush_o             = 1'b0;
    exec_handler_addr_o = '0;
    if (!rst) begin
      if (state == FLUSH) begin
        flush_o             = 1'b1;
        exec_handler_addr_o = latched_addr;
      end else if (exc_take) begin
        flush_o             = 1'b1;
        exec_handler_addr_o = target_addr;
      end else begin
        stall_o = therm;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      flush_cnt    <= '0;
      latched_addr <= '0;
    end else begin
      case (state)
        RUN: if (exc_take) begin
          latched_addr <= target_addr;
          if (FLUSH_CYCLES > 1) begin
            state     <= FLUSH;
            flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
          end
        end
        FLUSH: begin
          if (flush_cnt <= FC_W'(1)) state <= RUN;
          flush_cnt <= flush_cnt - FC_W'(1);
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt          <= '0;
      stall_timeout_o <= 1'b0;
      stall_cnt_o     <= '0;
    end else if (stall_o != '0) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
      if (wd_cnt != WD_W'(STALL_TIMEOUT)) wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_cnt >= WD_W'(STALL_TIMEOUT - 1)) stall_timeout_o <= 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed + random checks of three pipe_hazard_ctrl variants against a reference model
module tb_pipe_hazard_ctrl;

  localparam int TO = 4;
  localparam int FC [3] = '{1, 3, 4};

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  req;
  logic [31:0] exc;
  logic [31:0] epc;

  logic [5:0]  stall_v   [3];
  logic        flush_v   [3];
  logic [31:0] addr_v    [3];
  logic        to_v      [3];
  logic [31:0] cnt_v     [3];

  int compared = 0;
  int mismatched = 0;

  // reference state: remaining flush cycles after the current one, latched target, stall run length
  int          m_frem  [3];
  logic [31:0] m_laddr [3];
  int          m_run   [3];
  logic        m_to    [3];
  logic [31:0] m_cnt   [3];
  logic [5:0]  e_stall [3];
  logic        e_flush [3];
  logic [31:0] e_addr  [3];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .STALL_TIMEOUT(TO)) u_f1 (
    .clk(clk), .rst(rst), .stallreq_i(req), .exception_i(exc), .cp0_epc_i(epc),
    .stall_o(stall_v[0]), .flush_o(flush_v[0]), .exec_handler_addr_o(addr_v[0]),
    .stall_timeout_o(to_v[0]), .stall_cnt_o(cnt_v[0]));
  pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .STALL_TIMEOUT(TO)) u_f3 (
    .clk(clk), .rst(rst), .stallreq_i(req), .exception_i(exc), .cp0_epc_i(epc),
    .stall_o(stall_v[1]), .flush_o(flush_v[1]), .exec_handler_addr_o(addr_v[1]),
    .stall_timeout_o(to_v[1]), .stall_cnt_o(cnt_v[1]));
  pipe_hazard_ctrl #(.FLUSH_CYCLES(4), .STALL_TIMEOUT(TO)) u_f4 (
    .clk(clk), .rst(rst), .stallreq_i(req), .exception_i(exc), .cp0_epc_i(epc),
    .stall_o(stall_v[2]), .flush_o(flush_v[2]), .exec_handler_addr_o(addr_v[2]),
    .stall_timeout_o(to_v[2]), .stall_cnt_o(cnt_v[2]));

  function automatic logic [5:0] ref_stall(input logic [5:0] r);
    int top = -1;
    for (int k = 0; k < 6; k++) if (r[k]) top = k;
    return (top < 0) ? 6'd0 : 6'((1 << (top + 1)) - 1);
  endfunction

  function automatic logic [31:0] ref_addr(input logic [31:0] code, input logic [31:0] e);
    if (code == 32'd1)  return 32'h20;
    if (code == 32'd14) return e;
    return 32'h40;
  endfunction

  task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s[f%0d] observed=%0h expected=%0h", tag, FC[inst], obs, expv);
    end
  endtask

  // one cycle: drive, check combinational and registered outputs mid-cycle, advance the model at the edge
  task automatic step(input logic r, input logic [5:0] q, input logic [31:0] x, input logic [31:0] e);
    rst = r; req = q; exc = x; epc = e;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        e_stall[i] = '0; e_flush[i] = 1'b0; e_addr[i] = '0;
      end else if (m_frem[i] > 0) begin
        e_stall[i] = '0; e_flush[i] = 1'b1; e_addr[i] = m_laddr[i];
      end else if (x != 0) begin
        e_stall[i] = '0; e_flush[i] = 1'b1; e_addr[i] = ref_addr(x, e);
      end else begin
        e_stall[i] = ref_stall(q); e_flush[i] = 1'b0; e_addr[i] = '0;
      end
      chk("stall", i, 32'(stall_v[i]), 32'(e_stall[i]));
      chk("flush", i, 32'(flush_v[i]), 32'(e_flush[i]));
      chk("addr",  i, addr_v[i], e_addr[i]);
      chk("timeout", i, 32'(to_v[i]), 32'(m_to[i]));
      chk("stall_cnt", i, cnt_v[i], m_cnt[i]);
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        m_frem[i] = 0; m_laddr[i] = '0; m_run[i] = 0; m_to[i] = 1'b0; m_cnt[i] = '0;
      end else begin
        if (m_frem[i] > 0) m_frem[i]--;
        else if (x != 0) begin
          m_laddr[i] = e_addr[i];
          m_frem[i]  = FC[i] - 1;
        end
        if (e_stall[i] != 0) begin
          m_cnt[i]++;
          m_run[i]++;
          if (m_run[i] >= TO) m_to[i] = 1'b1;
        end else m_run[i] = 0;
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] codes [8];
    codes = '{32'd1, 32'd8, 32'd10, 32'd12, 32'd13, 32'd14, 32'd5, 32'd0};
    for (int i = 0; i < 3; i++) begin
      m_frem[i] = 0; m_laddr[i] = '0; m_run[i] = 0; m_to[i] = 1'b0; m_cnt[i] = '0;
    end
    rst = 1'b1; req = '0; exc = '0; epc = '0;
    #1;

    // reset with active stall and exception requests
    step(1'b1, 6'b001000, 32'd8, 32'h0);
    step(1'b1, 6'b001000, 32'd8, 32'h0);
    step(1'b0, 6'b001000, 32'd0, 32'h0);
    chk("post_rst_cnt", 0, cnt_v[0], 32'd1);

    // priority encoding
    step(1'b0, 6'b000100, 32'd0, 32'h0);
    step(1'b0, 6'b001100, 32'd0, 32'h0);
    step(1'b0, 6'b100000, 32'd0, 32'h0);
    step(1'b0, 6'b000000, 32'd0, 32'h0);
    chk("enc_cnt", 0, cnt_v[0], 32'd4);

    // exception codes, each followed by enough idle cycles for the longest flush
    foreach (codes[j]) if (codes[j] != 0) begin
      step(1'b0, 6'b001000, codes[j], 32'hBFC0_0100);
      step(1'b0, 6'b001000, 32'd0, 32'h0);
      step(1'b0, 6'b001000, 32'd0, 32'h0);
      step(1'b0, 6'b001000, 32'd0, 32'h0);
      step(1'b0, 6'b000000, 32'd0, 32'h0);
    end

    // flush hold with a second exception arriving during the hold
    step(1'b0, 6'b001000, 32'd8, 32'h0);
    step(1'b0, 6'b001000, 32'd1, 32'h0);
    chk("hold_addr", 1, addr_v[1], 32'h40);
    step(1'b0, 6'b000000, 32'd0, 32'h0);
    step(1'b0, 6'b000000, 32'd0, 32'h0);
    step(1'b0, 6'b000000, 32'd0, 32'h0);
    chk("hold_end", 1, 32'(flush_v[1]), 32'd0);

    // watchdog: 3 stalled, 1 free, 4 stalled
    step(1'b1, 6'b000000, 32'd0, 32'h0);
    repeat (3) step(1'b0, 6'b000100, 32'd0, 32'h0);
    step(1'b0, 6'b000000, 32'd0, 32'h0);
    repeat (3) step(1'b0, 6'b000100, 32'd0, 32'h0);
    chk("wd_not_yet", 0, 32'(to_v[0]), 32'd0);
    step(1'b0, 6'b000100, 32'd0, 32'h0);
    chk("wd_tripped", 0, 32'(to_v[0]), 32'd1);
    step(1'b0, 6'b000000, 32'd0, 32'h0);
    step(1'b0, 6'b000000, 32'd0, 32'h0);
    step(1'b1, 6'b000000, 32'd0, 32'h0);
    step(1'b0, 6'b000000, 32'd0, 32'h0);

    // reset in the second flush cycle
    step(1'b0, 6'b000000, 32'd8, 32'h0);
    step(1'b1, 6'b000000, 32'd0, 32'h0);
    step(1'b0, 6'b000000, 32'd0, 32'h0);
    chk("rst_mid_flush", 2, 32'(flush_v[2]), 32'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic        r;
      logic [31:0] x;
      r = ($urandom_range(0, 49) == 0);
      x = ($urandom_range(0, 5) == 0) ? codes[$urandom_range(0, 6)] : 32'd0;
      if (x == 32'd5 && $urandom_range(0, 1) == 1) x = $urandom;
      step(r, 6'($urandom), x, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
